// File: rtl/pj_mem_resp.sv
// pj_mem_resp: pj bus target that serves single or wrapping 4-beat line transfers
// from a synchronous SRAM-style store, with programmable first-beat and inter-beat wait states.
module pj_mem_resp #(
  parameter int MEM_AW     = 16,
  parameter int WAIT_FIRST = 2,
  parameter int WAIT_BEAT  = 0
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              pj_tv,
  input  logic              pj_ale,
  input  logic [3:0]        pj_type,
  input  logic [1:0]        pj_size,
  input  logic [31:0]       pj_addr,
  input  logic [31:0]       pj_data_in,
  output logic [31:0]       pj_data_out,
  output logic [1:0]        pj_ack,
  input  logic              err_inj,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, BEAT, GAP} state_t;
  state_t            state_q;
  logic [3:0]        wcnt_q;
  logic [1:0]        bcnt_q, size_q, boff_q;
  logic              single_q, write_q, err_q;
  logic [MEM_AW-1:0] waddr_q;
  logic              accept, err_d, last, beat, b2b, pre;
  logic [1:0]        nb, lo;

  assign accept = state_q == IDLE && pj_tv && !pj_ale;
  assign err_d  = (pj_addr >> (MEM_AW + 2)) != 32'd0
               || (pj_size == 2'b01 && pj_addr[0])
               || (pj_size[1] && pj_addr[1:0] != 2'b00)
               || (pj_type[1] && pj_size == 2'b11)
               || (!pj_type[1] && pj_addr[1:0] != 2'b00)
               || err_inj;
  assign last = single_q || bcnt_q == 2'd3;
  assign beat = state_q == BEAT;
  assign b2b  = beat && !last && !err_q && WAIT_BEAT == 0;
  // Reads are fetched one cycle ahead of their beat, so the address looks at the upcoming beat.
  assign pre  = ((state_q == WAIT || state_q == GAP) && wcnt_q == 4'd1) || b2b;
  assign nb   = (b2b && !write_q) ? bcnt_q + 2'd1 : bcnt_q;
  assign lo   = waddr_q[1:0] + nb;

  assign mem_addr    = {waddr_q[MEM_AW-1:2], lo};
  assign mem_re      = pre && !write_q && !err_q;
  assign mem_we      = beat && write_q && !err_q;
  assign mem_wdata   = pj_data_in;
  assign mem_be      = !mem_we ? 4'b0000 :
                       !single_q ? 4'b1111 :
                       size_q == 2'b00 ? 4'b1000 >> boff_q :
                       size_q == 2'b01 ? (boff_q[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign pj_ack      = !beat ? 2'b00 : err_q ? 2'b10 : 2'b01;
  assign pj_data_out = (beat && !write_q && !err_q) ? mem_rdata : 32'd0;
  assign busy        = state_q != IDLE;

  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state_q  <= IDLE;
      wcnt_q   <= 4'd0;
      bcnt_q   <= 2'd0;
      size_q   <= 2'd0;
      boff_q   <= 2'd0;
      single_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      waddr_q  <= '0;
    end else
      case (state_q)
        IDLE: if (accept) begin
          state_q  <= WAIT;
          wcnt_q   <= 4'(WAIT_FIRST);
          bcnt_q   <= 2'd0;
          size_q   <= pj_size;
          boff_q   <= pj_addr[1:0];
          single_q <= pj_type[1];
          write_q  <= pj_type[0];
          err_q    <= err_d;
          waddr_q  <= pj_addr[MEM_AW+1:2];
        end
        WAIT, GAP: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_q <= BEAT;
        end
        BEAT: if (last || err_q) state_q <= IDLE;
        else begin
          bcnt_q  <= bcnt_q + 2'd1;
          wcnt_q  <= 4'(WAIT_BEAT);
          state_q <= WAIT_BEAT > 0 ? GAP : BEAT;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_pj_mem_resp.sv
// tb_pj_mem_resp: scoreboard bench driving two responders (WAIT_BEAT=0 and WAIT_BEAT=2)
// from the same request stream, each backed by its own behavioural SRAM.
module tb_pj_mem_resp;
  typedef struct {
    logic [1:0]  ack;
    logic [31:0] data;
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    int          cyc;
  } exp_t;

  logic        clk = 0, reset_l = 0, pj_tv = 0, pj_ale = 1, err_inj = 0;
  logic [3:0]  pj_type = 0;
  logic [1:0]  pj_size = 0;
  logic [31:0] pj_addr = 0;
  logic [31:0] pj_data_in;
  logic [31:0] pj_data_out [2], mem_rdata [2], mem_wdata [2];
  logic [1:0]  pj_ack [2];
  logic [15:0] mem_addr [2];
  logic        mem_re [2], mem_we [2], busy [2];
  logic [3:0]  mem_be [2];

  logic [31:0] mem [logic [16:0]];
  exp_t        q [2][$];
  int          cyc = 0, errors = 0, checks = 0;
  int          re_cnt [2] = '{0, 0}, we_cnt [2] = '{0, 0};
  logic        prev_re [2] = '{0, 0};
  logic [15:0] prev_addr [2] = '{0, 0};
  exp_t        mon_e;
  logic        mon_ok;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pj_mem_resp #(.MEM_AW(16), .WAIT_FIRST(2), .WAIT_BEAT(2 * g)) u_dut (
      .clk(clk), .reset_l(reset_l), .pj_tv(pj_tv), .pj_ale(pj_ale), .pj_type(pj_type),
      .pj_size(pj_size), .pj_addr(pj_addr), .pj_data_in(pj_data_in),
      .pj_data_out(pj_data_out[g]), .pj_ack(pj_ack[g]), .err_inj(err_inj),
      .mem_addr(mem_addr[g]), .mem_re(mem_re[g]), .mem_rdata(mem_rdata[g]),
      .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_wdata(mem_wdata[g]), .busy(busy[g]));
  end

  function automatic logic [31:0] wd(input int c);
    return {c[23:0], 8'hAB};
  endfunction

  function automatic logic [31:0] rdm(input int g, input logic [15:0] a);
    logic [16:0] k;
    k = {g[0], a};
    return mem.exists(k) ? mem[k] : {16'h5EED, a};
  endfunction

  function automatic void wr(input int g, input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = rdm(g, a);
    for (int b = 0; b < 4; b++) if (be[3-b]) v[31-8*b -: 8] = d[31-8*b -: 8];
    mem[{g[0], a}] = v;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pj_data_in = wd(cyc);

  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      if (mem_re[g]) mem_rdata[g] <= rdm(g, mem_addr[g]);
      if (mem_we[g]) wr(g, mem_addr[g], mem_be[g], mem_wdata[g]);
    end

  always @(negedge clk)
    if (reset_l)
      for (int g = 0; g < 2; g++) begin
        if (mem_re[g]) re_cnt[g]++;
        if (mem_we[g]) we_cnt[g]++;
        if (!mem_we[g]) begin
          checks++;
          if (mem_be[g] !== 4'b0000) begin
            errors++;
            $display("FAIL be_idle dut%0d cyc=%0d mem_be=%b required 0000", g, cyc, mem_be[g]);
          end
        end
        if (pj_ack[g] !== 2'b00) begin
          checks++;
          if (q[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack dut%0d cyc=%0d ack=%b required no ack", g, cyc, pj_ack[g]);
          end else begin
            mon_e  = q[g].pop_front();
            mon_ok = pj_ack[g] === mon_e.ack && pj_data_out[g] === mon_e.data && cyc == mon_e.cyc
                  && mem_we[g] === mon_e.we
                  && (!mon_e.we || (mem_addr[g] === mon_e.addr && mem_be[g] === mon_e.be
                                    && mem_wdata[g] === wd(mon_e.cyc)))
                  && (mon_e.we || mon_e.ack != 2'b01 || (prev_re[g] === 1'b1 && prev_addr[g] === mon_e.addr));
            if (!mon_ok) begin
              errors++;
              $display("FAIL beat dut%0d got ack=%b data=%h cyc=%0d we=%b addr=%h be=%b wdata=%h prev_re=%b prev_addr=%h; required ack=%b data=%h cyc=%0d we=%b addr=%h be=%b wdata=%h",
                       g, pj_ack[g], pj_data_out[g], cyc, mem_we[g], mem_addr[g], mem_be[g], mem_wdata[g],
                       prev_re[g], prev_addr[g], mon_e.ack, mon_e.data, mon_e.cyc, mon_e.we, mon_e.addr,
                       mon_e.be, wd(mon_e.cyc));
            end
          end
        end
        prev_re[g]   = mem_re[g];
        prev_addr[g] = mem_addr[g];
      end

  task automatic request(input logic [3:0] t, input logic [1:0] s, input logic [31:0] a, input logic ei);
    exp_t e;
    int n;
    logic er;
    logic [1:0] w;
    er = a[31:18] != 14'd0 || (s == 2'b01 && a[0]) || (s >= 2'b10 && a[1:0] != 2'b00)
      || (t[1] && s == 2'b11) || (!t[1] && a[1:0] != 2'b00) || ei;
    n = (er || t[1]) ? 1 : 4;
    pj_tv = 1; pj_ale = 0; pj_type = t; pj_size = s; pj_addr = a; err_inj = ei;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < n; i++) begin
        w      = a[3:2] + 2'(i);
        e.ack  = er ? 2'b10 : 2'b01;
        e.we   = !er && t[0];
        e.addr = {a[17:4], w};
        e.cyc  = cyc + 3 + i * (2 * g + 1);
        e.data = (er || t[0]) ? 32'd0 : rdm(g, e.addr);
        e.be   = !t[1] ? 4'b1111 : s == 2'b00 ? 4'b0001 << (2'd3 - a[1:0]) :
                 s == 2'b01 ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        q[g].push_back(e);
      end
    @(posedge clk); #1;
    pj_tv = 0; pj_ale = 1; err_inj = 0;
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (i < 100 && (q[0].size() != 0 || q[1].size() != 0 || busy[0] || busy[1])) begin
      @(posedge clk); #1;
      i++;
    end
    checks++;
    if (i >= 100) begin
      errors++;
      $display("FAIL %s timeout pending=%0d/%0d busy=%b%b required drained and idle",
               name, q[0].size(), q[1].size(), busy[0], busy[1]);
      q[0].delete(); q[1].delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (pj_ack[g] !== 2'b00 || pj_data_out[g] !== 32'd0 || busy[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out dut%0d ack=%b data=%h busy=%b required 00/0/0", g, pj_ack[g], pj_data_out[g], busy[g]);
      end
      checks++;
      if (mem_re[g] !== 1'b0 || mem_we[g] !== 1'b0 || mem_be[g] !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mem dut%0d re=%b we=%b be=%b required 0/0/0000", g, mem_re[g], mem_we[g], mem_be[g]);
      end
    end
    reset_l = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int r [2];
    r = re_cnt;
    request(4'b0010, 2'b10, 32'h100, 1'b0);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (busy[g] !== 1'b1) begin
        errors++;
        $display("FAIL single_busy dut%0d busy=%b required 1", g, busy[g]);
      end
    end
    wait_done("single_read");
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (re_cnt[g] - r[g] != 1) begin
        errors++;
        $display("FAIL single_re_count dut%0d got %0d required 1", g, re_cnt[g] - r[g]);
      end
    end
  endtask

  task automatic test_line_read();
    int r [2];
    r = re_cnt;
    request(4'b0000, 2'b10, 32'h208, 1'b0);
    wait_done("line_read");
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (re_cnt[g] - r[g] != 4) begin
        errors++;
        $display("FAIL line_re_count dut%0d got %0d required 4", g, re_cnt[g] - r[g]);
      end
    end
  endtask

  task automatic test_partial_write();
    int r [2], w [2];
    r = re_cnt; w = we_cnt;
    request(4'b0011, 2'b00, 32'h101, 1'b0);
    wait_done("byte_write");
    request(4'b0011, 2'b01, 32'h102, 1'b0);
    wait_done("half_write");
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (we_cnt[g] - w[g] != 2 || re_cnt[g] != r[g]) begin
        errors++;
        $display("FAIL partial_strobes dut%0d we=%0d re=%0d required we=2 re=0", g, we_cnt[g] - w[g], re_cnt[g] - r[g]);
      end
    end
  endtask

  task automatic test_line_write();
    int w [2];
    w = we_cnt;
    request(4'b0001, 2'b10, 32'h40C, 1'b0);
    wait_done("line_write");
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (we_cnt[g] - w[g] != 4) begin
        errors++;
        $display("FAIL line_we_count dut%0d got %0d required 4", g, we_cnt[g] - w[g]);
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0]  tt [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [1:0]  ss [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] aa [5] = '{32'h0004_0000, 32'h102, 32'h100, 32'h100, 32'h206};
    logic        ee [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int r [2], w [2];
    r = re_cnt; w = we_cnt;
    for (int i = 0; i < 5; i++) begin
      request(tt[i], ss[i], aa[i], ee[i]);
      wait_done("error_case");
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (re_cnt[g] != r[g] || we_cnt[g] != w[g]) begin
        errors++;
        $display("FAIL error_strobes dut%0d re=%0d we=%0d required 0/0", g, re_cnt[g] - r[g], we_cnt[g] - w[g]);
      end
    end
    r = re_cnt;
    request(4'b0010, 2'b10, 32'h500, 1'b0);
    wait_done("after_error");
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (re_cnt[g] - r[g] != 1) begin
        errors++;
        $display("FAIL after_error_re dut%0d got %0d required 1", g, re_cnt[g] - r[g]);
      end
    end
  endtask

  task automatic test_ignored_ale();
    pj_tv = 1; pj_ale = 1; pj_type = 4'b0010; pj_size = 2'b10; pj_addr = 32'h100;
    repeat (2) begin @(posedge clk); #1; end
    pj_tv = 0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (busy[g] !== 1'b0) begin
        errors++;
        $display("FAIL ale_ignored dut%0d busy=%b required 0", g, busy[g]);
      end
    end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic test_back_to_back();
    request(4'b0010, 2'b10, 32'h504, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (busy[g] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle dut%0d busy=%b required 0", g, busy[g]);
      end
    end
    request(4'b0011, 2'b10, 32'h508, 1'b0);
    wait_done("back_to_back");
  endtask

  task automatic test_reset_mid();
    request(4'b0000, 2'b10, 32'h300, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (pj_ack[0] !== 2'b01) begin
      errors++;
      $display("FAIL mid_beat2 dut0 ack=%b required 01", pj_ack[0]);
    end
    reset_l = 0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (pj_ack[g] !== 2'b00 || mem_re[g] !== 1'b0 || mem_we[g] !== 1'b0 || busy[g] !== 1'b0) begin
        errors++;
        $display("FAIL async_abort dut%0d ack=%b re=%b we=%b busy=%b required 00/0/0/0",
                 g, pj_ack[g], mem_re[g], mem_we[g], busy[g]);
      end
      q[g].delete();
    end
    repeat (2) begin @(posedge clk); #1; end
    reset_l = 1;
    @(posedge clk); #1;
    request(4'b0010, 2'b10, 32'h304, 1'b0);
    wait_done("after_reset");
  endtask

  initial begin
    mem[{1'b0, 16'h40}] = 32'hCAFE_BABE;
    mem[{1'b1, 16'h40}] = 32'hCAFE_BABE;
    test_reset();
    test_single_read();
    test_line_read();
    test_partial_write();
    test_line_write();
    test_errors();
    test_ignored_ale();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pj_mem_resp.md
Name: pj_mem_resp

Overview:
- Memory-side responder for the pj bus: the target end of the request/ack protocol driven by the core's BIU arbiter.
- Accepts one request per address phase (pj_tv with pj_ale low).
- Performs a single transfer or a 4-beat cache-line transfer against a synchronous SRAM-style backing store, then returns pj_ack beats with programmable wait states.
- Used as the system-side bus model and as the on-chip memory controller front end.

Parameters:
MEM_AW, 16, backing-store word-address width; valid byte addresses satisfy pj_addr[31:MEM_AW+2]==0
WAIT_FIRST, 2, cycles from accept to first ack minus 1 (legal range 1..15)
WAIT_BEAT, 0, idle cycles between burst beats (0 = back-to-back acks, legal 0..15)

Ports:
clk  in  1  clock
reset_l  in  1  asynchronous active-low reset
pj_tv  in  1  transfer valid from core
pj_ale  in  1  address latch enable, active low; low with pj_tv marks the address phase
pj_type  in  4  [1]=1 single transfer, [1]=0 4-beat line; [0]=1 write, 0 read; [3:2] ignored
pj_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
pj_addr  in  32  byte address, sampled at accept
pj_data_in  in  32  write data from core, sampled in each write ack cycle
pj_data_out  out  32  read data to core
pj_ack  out  2  [0] normal ack, [1] error ack
err_inj  in  1  forces error response if high at accept
mem_addr  out  MEM_AW  word address to store
mem_re  out  1  read strobe; mem_rdata is valid the following cycle
mem_rdata  in  32  store read data
mem_we  out  1  write strobe
mem_be  out  4  byte enables, big-endian (be[3]=byte 0)
mem_wdata  out  32  write data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, counters 0, pj_ack=00, pj_data_out=0, mem_re=0, mem_we=0, mem_be=0, busy=0. Asserting reset mid-transaction aborts it immediately with no further ack or memory strobe.
- Accept: in IDLE, pj_tv=1 and pj_ale=0 in cycle T. Latch type, size, addr; set err_pend. pj_tv with pj_ale=1 in IDLE is ignored.
- err_pend is set by any of:
  - address out of range
  - misalignment (halfword with addr[0]=1; word with addr[1:0]!=0)
  - single-transfer size 11
  - err_inj=1
  - line request with addr[1:0]!=0
- States:
  - IDLE: on accept go to WAIT with wcnt=WAIT_FIRST.
  - WAIT: decrement wcnt; when wcnt reaches 1 go to BEAT.
  - BEAT: drive one ack for one cycle. On the last beat or on error go to IDLE. Otherwise go to GAP if WAIT_BEAT>0, else stay in BEAT.
  - GAP: count WAIT_BEAT cycles, then go to BEAT.
- First ack in cycle T+WAIT_FIRST+1; each later beat follows WAIT_BEAT+1 cycles after the previous one.
- Beat count:
  - Single transfer: 1 ack.
  - Line transfer: 4 acks, critical word first. Word address increments by 1 and wraps within the aligned 16-byte line: addr[3:2] sequence a, a+1, a+2, a+3 mod 4.
- Error:
  - The first BEAT drives pj_ack=10 and goes to IDLE.
  - No mem_re or mem_we is issued for the request.
  - pj_data_out=0.
- Reads:
  - mem_re is asserted with mem_addr in the cycle before each BEAT (last WAIT/GAP cycle, or the previous BEAT cycle when back-to-back).
  - pj_data_out = mem_rdata during BEAT, 0 otherwise.
- Writes:
  - In each BEAT, mem_we=1, mem_addr=beat address, mem_wdata=pj_data_in.
  - mem_be: byte gives one-hot be[3-addr[1:0]]; halfword gives 1100 if addr[1]=0, else 0011; word and line beats give 1111.
  - mem_be=0 when mem_we=0.
- pj_ack is 00 outside BEAT; 01 and 10 are never asserted together.
- Back-to-back requests: the cycle after the final ack the block is in IDLE and may accept a new request in that same cycle.
- busy = (state != IDLE).

Test Plan:
- Single word read, WAIT_FIRST=2, addr 0x100, store word 0x40=0xCAFEBABE: accept at T -> mem_re at T+2 with mem_addr=0x40; pj_ack=01 and pj_data_out=0xCAFEBABE at T+3; IDLE at T+4.
- Line read at addr 0x208, WAIT_BEAT=0: 4 acks on consecutive cycles, mem_addr sequence 0x82, 0x83, 0x80, 0x81.
- Byte write addr 0x101, data 0x000000AB (type 0011, size 00): one ack, mem_we=1, mem_be=0100, mem_addr=0x40.
- Line write with WAIT_BEAT=2: acks spaced 3 cycles apart, pj_data_in captured on each of the 4 beats, 4 mem_we pulses.
- Error cases -> single pj_ack=10, no mem strobes, next request accepted normally:
  - addr 0x0004_0000 with MEM_AW=16;
  - word read at addr 0x102;
  - err_inj=1 at accept.
- reset_l pulsed low during beat 2 of a line read: pj_ack, mem_re, mem_we go to 0 asynchronously; after release busy=0 and a new request completes normally.
